// File: rtl/eeprom_word_writer.sv
// eeprom_word_writer: programs one 32-bit word into a 24LC256-class I2C EEPROM
// (4-byte page write, then ACK polling). Optional power-up bus clear: EEPROM_BUS_CLEAR_EN.
module eeprom_word_writer #(
   parameter int unsigned CLK_DIV  = 125,
   parameter logic [6:0]  DEV_ADDR = 7'h50,
   parameter int unsigned POLL_MAX = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [12:0] word_addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        scl_oe,
   output logic        sda_oe,
   input  logic        sda_in
);

   localparam int TW = $clog2(CLK_DIV);
   localparam int PW = $clog2(POLL_MAX + 1);
   localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_DIV - 1);
   localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_MAX - 1);
   localparam logic [PW-1:0] POLL_MAX_V = PW'(POLL_MAX);
   localparam logic [5:0]    ACK_SAMPLE = 6'd34;

`ifdef EEPROM_BUS_CLEAR_EN
   localparam logic CLEAR_ON_RESET = 1'b1;
`else
   localparam logic CLEAR_ON_RESET = 1'b0;
`endif

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLEAR,
      S_CLR_STOP,
      S_START,
      S_SEND,
      S_STOP,
      S_POLL_START,
      S_POLL_DEV,
      S_POLL_STOP,
      S_ERR_STOP,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
   logic [5:0]      step_q, step_d;
   logic [2:0]      byte_idx_q, byte_idx_d;
   logic            nack_q, nack_d;
   logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
   logic            err_q, err_d;
   logic [12:0]     addr_q, addr_d;
   logic [31:0]     data_q, data_d;
   logic            clear_pend_q, clear_pend_d;
   logic            scl_oe_q, scl_oe_d;
   logic            sda_oe_q, sda_oe_d;

   logic            run;
   logic            tick;
   logic            busy_int;
   logic            accept;
   logic            state_end;
   logic [5:0]      step_last;
   logic [3:0]      bit_idx;
   logic [7:0]      cur_byte;
   logic [15:0]     byte_addr;

   assign run       = (state_q != S_IDLE) && (state_q != S_DONE);
   assign busy_int  = clear_pend_q || run;
   assign tick      = run && (tick_cnt_q == TICK_LAST);
   assign accept    = start && !busy_int;
   assign state_end = tick && (step_q == step_last);
   assign bit_idx   = step_q[5:2];
   assign byte_addr = {1'b0, addr_q, 2'b00};

   // Each state lasts a fixed number of ticks; a SEND covers 9 bits of 4 quarters.
   always_comb begin
      case (state_q)
         S_START, S_POLL_START:        step_last = 6'd3;
         S_SEND, S_POLL_DEV, S_CLEAR:  step_last = 6'd35;
         default:                      step_last = 6'd6;
      endcase
   end

   always_comb begin
      cur_byte = {DEV_ADDR, 1'b0};
      if (state_q == S_SEND) begin
         case (byte_idx_q)
            3'd1:    cur_byte = byte_addr[15:8];
            3'd2:    cur_byte = byte_addr[7:0];
            3'd3:    cur_byte = data_q[7:0];
            3'd4:    cur_byte = data_q[15:8];
            3'd5:    cur_byte = data_q[23:16];
            3'd6:    cur_byte = data_q[31:24];
            default: cur_byte = {DEV_ADDR, 1'b0};
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (clear_pend_q) begin
               state_d = S_CLEAR;
            end else if (start) begin
               state_d = S_START;
            end
         end
         S_CLEAR:      if (state_end) state_d = S_CLR_STOP;
         S_CLR_STOP:   if (state_end) state_d = S_IDLE;
         S_START:      if (state_end) state_d = S_SEND;
         S_SEND: begin
            if (state_end) begin
               if (nack_q) begin
                  state_d = S_ERR_STOP;
               end else if (byte_idx_q == 3'd6) begin
                  state_d = S_STOP;
               end
            end
         end
         S_STOP:       if (state_end) state_d = S_POLL_START;
         S_POLL_START: if (state_end) state_d = S_POLL_DEV;
         S_POLL_DEV:   if (state_end) state_d = S_POLL_STOP;
         S_POLL_STOP: begin
            if (state_end) begin
               if (!nack_q || (poll_cnt_q >= POLL_LAST)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_POLL_START;
               end
            end
         end
         S_ERR_STOP:   if (state_end) state_d = S_DONE;
         S_DONE:       state_d = start ? S_START : S_IDLE;
         default:      state_d = S_IDLE;
      endcase
   end

   // Output logic; bus enables are registered so the pins never glitch.
   always_comb begin
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
      busy     = busy_int;
      done     = (state_q == S_DONE);
      err      = err_q;
      scl_oe   = scl_oe_q;
      sda_oe   = sda_oe_q;
      case (state_q)
         S_CLEAR: begin
            scl_oe_d = ~step_q[1];
         end
         S_START, S_POLL_START: begin
            sda_oe_d = step_q[1];
         end
         S_SEND, S_POLL_DEV: begin
            scl_oe_d = ~step_q[1];
            if (!bit_idx[3]) begin
               sda_oe_d = ~cur_byte[3'd7 - bit_idx[2:0]];
            end
         end
         S_STOP, S_POLL_STOP, S_ERR_STOP, S_CLR_STOP: begin
            scl_oe_d = (step_q == 6'd0);
            sda_oe_d = (step_q <= 6'd1);
         end
         default: begin
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
         end
      endcase
   end

   // Datapath next-state
   always_comb begin
      tick_cnt_d   = tick_cnt_q;
      step_d       = step_q;
      byte_idx_d   = byte_idx_q;
      nack_d       = nack_q;
      poll_cnt_d   = poll_cnt_q;
      err_d        = err_q;
      addr_d       = addr_q;
      data_d       = data_q;
      clear_pend_d = clear_pend_q;

      if (!run || tick) begin
         tick_cnt_d = '0;
      end else begin
         tick_cnt_d = tick_cnt_q + TW'(1);
      end

      if (tick) begin
         step_d = state_end ? 6'd0 : step_q + 6'd1;
      end

      if ((state_q == S_IDLE) && clear_pend_q) begin
         clear_pend_d = 1'b0;
      end

      if (accept) begin
         addr_d     = word_addr;
         data_d     = wdata;
         err_d      = 1'b0;
         poll_cnt_d = '0;
         byte_idx_d = 3'd0;
      end

      // ACK slot is sampled as SCL has been high for one quarter.
      if (tick && ((state_q == S_SEND) || (state_q == S_POLL_DEV)) && (step_q == ACK_SAMPLE)) begin
         nack_d = sda_in;
      end

      if (state_end && (state_q == S_SEND) && !nack_q) begin
         byte_idx_d = byte_idx_q + 3'd1;
      end

      if (state_end && (state_q == S_POLL_STOP) && nack_q) begin
         if (poll_cnt_q != POLL_MAX_V) begin
            poll_cnt_d = poll_cnt_q + PW'(1);
         end
         if (poll_cnt_q >= POLL_LAST) begin
            err_d = 1'b1;
         end
      end

      if (state_end && (state_q == S_ERR_STOP)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt_q   <= '0;
         step_q       <= '0;
         byte_idx_q   <= '0;
         nack_q       <= 1'b0;
         poll_cnt_q   <= '0;
         err_q        <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         clear_pend_q <= CLEAR_ON_RESET;
         scl_oe_q     <= 1'b0;
         sda_oe_q     <= 1'b0;
      end else begin
         tick_cnt_q   <= tick_cnt_d;
         step_q       <= step_d;
         byte_idx_q   <= byte_idx_d;
         nack_q       <= nack_d;
         poll_cnt_q   <= poll_cnt_d;
         err_q        <= err_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         clear_pend_q <= clear_pend_d;
         scl_oe_q     <= scl_oe_d;
         sda_oe_q     <= sda_oe_d;
      end
   end

endmodule

// File: tb/tb_eeprom_word_writer.sv
// Randomised bench for eeprom_word_writer: an I2C slave model on the bus plus a
// byte-level expectation built from the word address, data and ACK/NACK scenario.
module tb_eeprom_word_writer;

   localparam int CLK_DIV  = 4;
   localparam int POLL_MAX = 4;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [12:0] word_addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic        scl_oe;
   logic        sda_oe;
   logic        sda_in;
   logic        slave_pull;

   int n_checks;
   int n_errors;

   // slave / bus monitor state
   logic [7:0] wbytes[$];
   int         starts, stops, dones, poll_bad, bitcnt;
   logic [7:0] shreg;
   logic       ack_now;
   logic       prev_scl, prev_sda;
   int         mon_req, mon_seen;
   int         cfg_nack_byte, cfg_poll_nacks;

   assign sda_in = ~(sda_oe | slave_pull);

   eeprom_word_writer #(
      .CLK_DIV (CLK_DIV),
      .DEV_ADDR(7'h50),
      .POLL_MAX(POLL_MAX)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .word_addr(word_addr),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .scl_oe   (scl_oe),
      .sda_oe   (sda_oe),
      .sda_in   (sda_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // I2C slave: records write-phase bytes, ACKs/NACKs per scenario, counts START/STOP.
   initial begin
      logic scl_now, sda_now;
      slave_pull = 1'b0;
      prev_scl = 1'b1;
      prev_sda = 1'b1;
      starts = 0; stops = 0; dones = 0; poll_bad = 0; bitcnt = 0;
      shreg = 8'h00; ack_now = 1'b1; mon_seen = 0;
      forever begin
         @(negedge clk);
         scl_now = !scl_oe;
         sda_now = !sda_oe;
         if (mon_req != mon_seen) begin
            mon_seen = mon_req;
            wbytes.delete();
            starts = 0; stops = 0; dones = 0; poll_bad = 0; bitcnt = 0;
            slave_pull = 1'b0;
         end else if (prev_scl && scl_now && prev_sda && !sda_now) begin
            starts++;
            bitcnt = 0;
            slave_pull = 1'b0;
         end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
            stops++;
            bitcnt = 0;
            slave_pull = 1'b0;
         end else if (!prev_scl && scl_now) begin
            if (bitcnt < 8) begin
               shreg = {shreg[6:0], sda_now};
               bitcnt++;
               if (bitcnt == 8) begin
                  if (starts == 1) begin
                     ack_now = (cfg_nack_byte != wbytes.size());
                     wbytes.push_back(shreg);
                  end else begin
                     if (shreg != 8'hA0) poll_bad++;
                     ack_now = ((starts - 1) > cfg_poll_nacks);
                  end
               end
            end else if (bitcnt == 8) begin
               bitcnt = 9;
            end
         end else if (prev_scl && !scl_now) begin
            if (bitcnt == 8) begin
               slave_pull = ack_now;
            end else if (bitcnt == 9) begin
               slave_pull = 1'b0;
               bitcnt = 0;
            end
         end
         if (done) dones++;
         prev_scl = scl_now;
         prev_sda = sda_now;
      end
   end

   task automatic clear_monitor(input int nack_byte, input int poll_nacks);
      @(posedge clk);
      #1;
      cfg_nack_byte  = nack_byte;
      cfg_poll_nacks = poll_nacks;
      mon_req++;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic run_txn(input logic [12:0] a, input logic [31:0] d,
                          input int nack_byte, input int poll_nacks, input bit mid_start);
      logic [7:0] exp_b[$];
      int  a16, exp_polls, n_wait;
      bit  exp_err, seen;

      // expectation straight from the protocol rules
      a16 = int'(a) * 4;
      exp_b.push_back(8'h50 * 2);
      exp_b.push_back(8'((a16 >> 8) & 255));
      exp_b.push_back(8'(a16 & 255));
      for (int i = 0; i < 4; i++) exp_b.push_back(8'((d >> (8 * i)) & 255));
      if (nack_byte >= 0) begin
         while (exp_b.size() > nack_byte + 1) void'(exp_b.pop_back());
         exp_polls = 0;
         exp_err   = 1'b1;
      end else begin
         exp_polls = (poll_nacks + 1 < POLL_MAX) ? poll_nacks + 1 : POLL_MAX;
         exp_err   = (poll_nacks >= POLL_MAX);
      end

      clear_monitor(nack_byte, poll_nacks);
      word_addr = a;
      wdata     = d;
      start     = 1'b1;
      @(negedge clk);
      check("accept_busy", busy, 1);
      check("accept_err", err, 0);
      start = 1'b0;

      if (mid_start) begin
         repeat (200) @(negedge clk);
         check("mid_busy", busy, 1);
         word_addr = 13'h1FFF;
         wdata     = 32'h12345678;
         start     = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end

      seen = 1'b0;
      n_wait = 0;
      while (!seen && n_wait < 5000) begin
         @(negedge clk);
         n_wait++;
         if (done) seen = 1'b1;
      end
      check("done_seen", seen, 1);
      check("done_busy", busy, 0);
      check("done_err", err, exp_err);

      repeat (3) @(negedge clk);
      check("done_count", dones, 1);
      check("err_hold", err, exp_err);
      check("nbytes", wbytes.size(), exp_b.size());
      for (int i = 0; i < exp_b.size(); i++) begin
         if (i < wbytes.size()) check($sformatf("byte%0d", i), wbytes[i], exp_b[i]);
      end
      check("starts", starts, 1 + exp_polls);
      check("stops", stops, 1 + exp_polls);
      check("poll_bytes", poll_bad, 0);
      $display("txn addr=%h data=%h nack_byte=%0d poll_nacks=%0d bytes=%0d polls=%0d err=%0d",
               a, d, nack_byte, poll_nacks, wbytes.size(), starts - 1, err);
   endtask

   initial begin
      int nb, pn, r, n_wait;
      logic [12:0] ra;
      logic [31:0] rd;
      n_checks = 0;
      n_errors = 0;
      mon_req = 0;
      cfg_nack_byte = -1;
      cfg_poll_nacks = 0;
      reset_n = 1'b0;
      start = 1'b0;
      word_addr = '0;
      wdata = '0;

      repeat (3) @(negedge clk);
      check("rst_scl", scl_oe, 0);
      check("rst_sda", sda_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_busy", busy, 0);

      run_txn(13'h0010, 32'hDEADBEEF, -1, 0, 1'b0);
      run_txn(13'h0010, 32'hDEADBEEF, -1, 3, 1'b0);
      run_txn(13'h0123, 32'hCAFEF00D, -1, 100, 1'b0);
      repeat (50) @(negedge clk);
      check("err_sticky", err, 1);
      run_txn(13'h0010, 32'hDEADBEEF, 2, 0, 1'b0);
      run_txn(13'h0010, 32'hDEADBEEF, -1, 0, 1'b1);

      // reset in the middle of data byte D1
      clear_monitor(-1, 0);
      word_addr = 13'h0010;
      wdata = 32'hDEADBEEF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_wait = 0;
      while (wbytes.size() < 4 && n_wait < 3000) begin
         @(negedge clk);
         n_wait++;
      end
      repeat (40) @(negedge clk);
      check("rst_in_d1", wbytes.size(), 4);
      check("rst_pre_busy", busy, 1);
      #1;
      reset_n = 1'b0;
      #1;
      check("arst_scl", scl_oe, 0);
      check("arst_sda", sda_oe, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      run_txn(13'h0000, 32'h00000001, -1, 0, 1'b0);

      for (int t = 0; t < 6; t++) begin
         ra = 13'($urandom_range(0, 8191));
         rd = $urandom;
         r  = int'($urandom_range(0, 9));
         nb = -1;
         if (r < 3) nb = int'($urandom_range(0, 6));
         pn = int'($urandom_range(0, 5));
         run_txn(ra, rd, nb, pn, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/eeprom_word_writer.md
Name: eeprom_word_writer

Overview:
- Writes one 32-bit instruction word into an external I2C serial EEPROM (24LC256-class, 16-bit byte address). Used to program the image that the EEPROM instruction-fetch path later reads back.
- Splits the word into 4 bytes, issues one I2C page write, then ACK-polls until the EEPROM's internal write cycle finishes.
- Drives the bus open-drain style: output-enable high pulls the line low.

Parameters:
- CLK_DIV, 125, system clocks per SCL quarter-period (50 MHz gives 100 kHz SCL); must be >= 2.
- DEV_ADDR, 7'h50, 7-bit I2C device address.
- POLL_MAX, 255, maximum ACK-poll attempts before the write is flagged as an error.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only while busy=0
- word_addr  in  13  word address; byte address = {word_addr, 2'b00}, zero-extended to 16 bits
- wdata  in  32  word to write
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at the end of every transaction (success or error)
- err  out  1  NACK or poll timeout; held until the next accepted start
- scl_oe  out  1  1 = pull SCL low
- sda_oe  out  1  1 = pull SDA low
- sda_in  in  1  sampled SDA line, already synchronised externally

Behaviour:
- Reset (async, reset_n=0):
  - scl_oe=0, sda_oe=0 (bus released); busy=0, done=0, err=0.
  - FSM goes to IDLE; tick counter and poll counter cleared.
  - Reset mid-transaction releases both lines immediately. No STOP is generated.
- Tick generator: a counter produces a 1-cycle tick every CLK_DIV clocks while busy. Each bit occupies 4 ticks (q0..q3):
  - q0, q1: SCL low; SDA updated at q0.
  - q2, q3: SCL high; SDA sampled at the start of q3.
- Accept:
  - start with busy=0 latches word_addr and wdata, clears err, and sets busy on the next cycle.
  - start while busy=1 is ignored; the latched values are unchanged.
- Byte order: little-endian. wdata[7:0] goes to byte address A, [15:8] to A+1, [23:16] to A+2, [31:24] to A+3.
  - A is 4-aligned, so the write never crosses a 64-byte page.
- FSM states: IDLE -> START -> SEND(DEVW) -> SEND(ADDR_H) -> SEND(ADDR_L) -> SEND(D0..D3) -> STOP -> POLL_START -> POLL_DEV -> POLL_STOP -> DONE.
  - Any NACK before STOP goes to ERR_STOP.
- START: SCL high with SDA released for 2 ticks, then SDA pulled low for 2 ticks.
- SEND:
  - 8 bits MSB first, then a 9th ACK bit with SDA released.
  - sda_in=0 at q3 of the ACK bit means ACK; 1 means NACK.
  - DEVW byte = {DEV_ADDR, 1'b0}.
- STOP: SCL low with SDA low, then SCL high, then SDA released; 1 tick each, plus a 4-tick bus-free gap.
- Polling:
  - POLL_DEV sends START + DEVW.
  - ACK: STOP, then DONE.
  - NACK: STOP, poll counter increments, retry from POLL_START.
  - When the counter reaches POLL_MAX: err=1, then DONE.
- ERR_STOP: generates STOP, sets err=1, then DONE.
- DONE: done=1 for exactly one clk; busy falls in the same cycle. A start in the following cycle is accepted.
- Counter widths:
  - tick counter: $clog2(CLK_DIV).
  - poll counter: $clog2(POLL_MAX+1); saturates at POLL_MAX, no wrap.

Optional Feature:
- Macro EEPROM_BUS_CLEAR_EN.
- Defined:
  - After reset deassertion, the block first runs a bus-clear: 9 SCL pulses with SDA released, then STOP.
  - busy=1 during the clear. start is ignored until the clear completes. done is not pulsed for the clear.
- Undefined: the block is idle immediately after reset.

Test Plan:
- CLK_DIV=4, word_addr=13'h0010, wdata=32'hDEADBEEF, model ACKs everything -> bus bytes A0,00,40,EF,BE,AD,DE, then STOP; first poll ACKed; exactly one done pulse; err=0.
- Same write, model NACKs the first 3 polls -> 4 POLL_STARTs observed; done after the 4th; err=0.
- POLL_MAX=2, model always NACKs polls -> 2 poll attempts; done with err=1; err stays 1 until the next start.
- Model NACKs ADDR_L -> no data bytes sent; STOP follows the ACK slot; done with err=1; busy=0 after done.
- start pulsed mid-transaction with wdata=32'h12345678 -> ignored; bus still carries EF,BE,AD,DE.
- reset_n low during D1 -> scl_oe=0 and sda_oe=0 the same cycle; busy=0, done=0; a later start with word_addr=0, wdata=1 writes A0,00,00,01,00,00,00 correctly.
